// File: rtl/ysyx_22041207_pipe_ctrl.sv
// rtl/ysyx_22041207_pipe_ctrl.sv - pipeline hazard/stall/flush controller
module ysyx_22041207_pipe_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  id_rs1addr,
    input  logic [4:0]  id_rs2addr,
    input  logic        id_use_rs1,
    input  logic        id_use_rs2,
    input  logic [4:0]  ex_rwaddr,
    input  logic        ex_writeRD,
    input  logic        ex_memoryReadWen,
    input  logic        ex_redirect,
    input  logic        ex_mdu_start,
    input  logic        mdu_done,
    input  logic        mem_busy,
    output logic        pc_hold,
    output logic        ifid_bubble,
    output logic        ifid_flush,
    output logic        idex_bubble,
    output logic        idex_flush,
    output logic        clear_afterID,
    output logic        exmem_hold,
    output logic        exmem_clear,
    output logic        mdu_timeout,
    output logic [2:0]  state,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
);

    typedef enum logic [2:0] {
        ST_RUN   = 3'd0,
        ST_LDUSE = 3'd1,
        ST_MDU   = 3'd2,
        ST_MEMW  = 3'd3
    } state_e;

    state_e      state_q, state_d;
    state_e      ret_q, ret_d;
    state_e      eff_state;
    logic [7:0]  wd_q, wd_d;
    logic        timeout_q, timeout_d;
    logic [31:0] stall_q, stall_d;
    logic [31:0] flush_q, flush_d;
    logic        load_use;

    always_comb begin
        load_use = ex_memoryReadWen & ex_writeRD & (ex_rwaddr != 5'd0) &
                   ((id_use_rs1 & (id_rs1addr == ex_rwaddr)) |
                    (id_use_rs2 & (id_rs2addr == ex_rwaddr)));
    end

    always_comb begin
        pc_hold       = 1'b0;
        ifid_bubble   = 1'b0;
        ifid_flush    = 1'b0;
        idex_bubble   = 1'b0;
        idex_flush    = 1'b0;
        clear_afterID = 1'b0;
        exmem_hold    = 1'b0;
        exmem_clear   = 1'b0;
        state_d       = state_q;
        ret_d         = ret_q;
        wd_d          = wd_q;
        timeout_d     = timeout_q;
        stall_d       = stall_q;
        flush_d       = flush_q;
        // Leaving MEMW behaves exactly as the state it interrupted.
        eff_state     = (state_q == ST_MEMW) ? ret_q : state_q;

        if (!rst_n) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (mem_busy) begin
            pc_hold     = 1'b1;
            ifid_bubble = 1'b1;
            idex_bubble = 1'b1;
            exmem_hold  = 1'b1;
            state_d     = ST_MEMW;
            if (state_q != ST_MEMW) begin
                ret_d = (state_q == ST_MDU) ? ST_MDU : ST_RUN;
            end
        end else if (ex_redirect) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            state_d    = ST_RUN;
            if (flush_q != 32'hFFFF_FFFF) begin
                flush_d = flush_q + 32'd1;
            end
        end else begin
            case (eff_state)
                ST_MDU: begin
                    if (mdu_done) begin
                        state_d = ST_RUN;
                    end else begin
                        pc_hold     = 1'b1;
                        ifid_bubble = 1'b1;
                        idex_bubble = 1'b1;
                        exmem_clear = 1'b1;
                        wd_d        = wd_q + 8'd1;
                        if (wd_q == 8'd254) begin
                            timeout_d = 1'b1;
                            state_d   = ST_RUN;
                        end else begin
                            state_d = ST_MDU;
                        end
                    end
                end
                ST_LDUSE: state_d = ST_RUN;
                default: begin
                    if (ex_mdu_start) begin
                        wd_d    = 8'd0;
                        state_d = mdu_done ? ST_RUN : ST_MDU;
                    end else if (load_use) begin
                        pc_hold       = 1'b1;
                        ifid_bubble   = 1'b1;
                        clear_afterID = 1'b1;
                        state_d       = ST_LDUSE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            endcase
        end

        if (pc_hold && (stall_q != 32'hFFFF_FFFF)) begin
            stall_d = stall_q + 32'd1;
        end
        mdu_timeout = timeout_q & rst_n;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_RUN;
            ret_q     <= ST_RUN;
            wd_q      <= 8'd0;
            timeout_q <= 1'b0;
            stall_q   <= 32'd0;
            flush_q   <= 32'd0;
        end else begin
            state_q   <= state_d;
            ret_q     <= ret_d;
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
            stall_q   <= stall_d;
            flush_q   <= flush_d;
        end
    end

    assign state     = state_q;
    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;

endmodule

// File: tb/tb_ysyx_22041207_pipe_ctrl.sv
// tb/tb_ysyx_22041207_pipe_ctrl.sv - scoreboard bench for the pipeline controller
module tb_ysyx_22041207_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  id_rs1addr, id_rs2addr, ex_rwaddr;
    logic        id_use_rs1, id_use_rs2, ex_writeRD, ex_memoryReadWen;
    logic        ex_redirect, ex_mdu_start, mdu_done, mem_busy;
    logic        pc_hold, ifid_bubble, ifid_flush, idex_bubble, idex_flush;
    logic        clear_afterID, exmem_hold, exmem_clear, mdu_timeout;
    logic [2:0]  state;
    logic [31:0] stall_cnt, flush_cnt;

    ysyx_22041207_pipe_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs1addr(id_rs1addr), .id_rs2addr(id_rs2addr),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rwaddr(ex_rwaddr), .ex_writeRD(ex_writeRD), .ex_memoryReadWen(ex_memoryReadWen),
        .ex_redirect(ex_redirect), .ex_mdu_start(ex_mdu_start), .mdu_done(mdu_done),
        .mem_busy(mem_busy),
        .pc_hold(pc_hold), .ifid_bubble(ifid_bubble), .ifid_flush(ifid_flush),
        .idex_bubble(idex_bubble), .idex_flush(idex_flush), .clear_afterID(clear_afterID),
        .exmem_hold(exmem_hold), .exmem_clear(exmem_clear), .mdu_timeout(mdu_timeout),
        .state(state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [8:0]  ctl;
        logic [2:0]  st;
        logic [31:0] sc;
        logic [31:0] fc;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: pipeline "mode", the mode to resume after a memory wait,
    // and how many cycles the current multiply/divide has been stalling.
    localparam int RUN = 0, LDUSE = 1, MDU = 2, MEMW = 3;
    int          m_mode = RUN, m_back = RUN, m_wait = 0;
    bit          m_to = 1'b0;
    logic [31:0] m_stall = 0, m_flush = 0;

    task automatic model_step();
        bit   ph = 0, ib = 0, ifl = 0, idb = 0, idf = 0, clr = 0, eh = 0, ec = 0;
        bit   hazard;
        int   mode, nxt;
        exp_t e;
        e.st = 3'(m_mode);
        e.sc = m_stall;
        e.fc = m_flush;
        if (!rst_n) begin
            e.ctl = 9'b001010000;
            q.push_back(e);
            m_mode = RUN; m_back = RUN; m_wait = 0; m_to = 0; m_stall = 0; m_flush = 0;
            return;
        end
        hazard = ex_memoryReadWen && ex_writeRD && ex_rwaddr != 0 &&
                 ((id_use_rs1 && id_rs1addr == ex_rwaddr) || (id_use_rs2 && id_rs2addr == ex_rwaddr));
        e.ctl[0] = m_to;
        nxt = RUN;
        if (mem_busy) begin
            ph = 1; ib = 1; idb = 1; eh = 1;
            if (m_mode != MEMW) m_back = (m_mode == MDU) ? MDU : RUN;
            nxt = MEMW;
        end else begin
            mode = (m_mode == MEMW) ? m_back : m_mode;
            if (ex_redirect) begin
                ifl = 1; idf = 1;
                if (m_flush != 32'hFFFF_FFFF) m_flush++;
            end else if (mode == MDU) begin
                if (!mdu_done) begin
                    ph = 1; ib = 1; idb = 1; ec = 1;
                    m_wait++;
                    if (m_wait == 255) m_to = 1;
                    else nxt = MDU;
                end
            end else if (mode == RUN) begin
                if (ex_mdu_start) begin
                    m_wait = 0;
                    if (!mdu_done) nxt = MDU;
                end else if (hazard) begin
                    ph = 1; ib = 1; clr = 1;
                    nxt = LDUSE;
                end
            end
        end
        e.ctl[8:1] = {ph, ib, ifl, idb, idf, clr, eh, ec};
        q.push_back(e);
        if (ph && m_stall != 32'hFFFF_FFFF) m_stall++;
        m_mode = nxt;
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst_n = 1; id_rs1addr = 0; id_rs2addr = 0; id_use_rs1 = 0; id_use_rs2 = 0;
        ex_rwaddr = 0; ex_writeRD = 0; ex_memoryReadWen = 0;
        ex_redirect = 0; ex_mdu_start = 0; mdu_done = 0; mem_busy = 0;
    endtask

    task automatic load_x5();
        ex_memoryReadWen = 1; ex_writeRD = 1; ex_rwaddr = 5;
        id_rs1addr = 5; id_use_rs1 = 1; id_rs2addr = 1; id_use_rs2 = 1;
    endtask

    task automatic rand_inputs();
        rst_n            = ($urandom_range(0, 99) >= 1);
        id_rs1addr       = 5'($urandom_range(0, 3));
        id_rs2addr       = 5'($urandom_range(0, 3));
        ex_rwaddr        = 5'($urandom_range(0, 3));
        id_use_rs1       = 1'($urandom);
        id_use_rs2       = 1'($urandom);
        ex_writeRD       = ($urandom_range(0, 99) < 80);
        ex_memoryReadWen = ($urandom_range(0, 99) < 40);
        ex_redirect      = ($urandom_range(0, 99) < 8);
        ex_mdu_start     = ($urandom_range(0, 99) < 10);
        mdu_done         = ($urandom_range(0, 99) < 15);
        mem_busy         = ($urandom_range(0, 99) < 8);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                n_tests += 3;
                if ({pc_hold, ifid_bubble, ifid_flush, idex_bubble, idex_flush, clear_afterID,
                     exmem_hold, exmem_clear, mdu_timeout} !== e.ctl) begin
                    n_fail++;
                    $display("FAIL ctl t=%0t got=%b exp=%b", $time,
                             {pc_hold, ifid_bubble, ifid_flush, idex_bubble, idex_flush,
                              clear_afterID, exmem_hold, exmem_clear, mdu_timeout}, e.ctl);
                end
                if (state !== e.st) begin
                    n_fail++;
                    $display("FAIL state t=%0t got=%0d exp=%0d", $time, state, e.st);
                end
                if (stall_cnt !== e.sc || flush_cnt !== e.fc) begin
                    n_fail++;
                    $display("FAIL counters t=%0t got stall=%0d flush=%0d exp stall=%0d flush=%0d",
                             $time, stall_cnt, flush_cnt, e.sc, e.fc);
                end
            end
        end
    end

    initial begin : stimulus
        idle();
        @(posedge clk);
        #1;
        // Reset with noisy inputs.
        repeat (2) begin rand_inputs(); rst_n = 0; cyc(); end
        idle(); cyc();
        // Load-use on rs1, then idle.
        load_x5(); cyc();
        idle(); cyc(); cyc();
        // Load to x0 read by ID, and rs2 match with use_rs2=0.
        load_x5(); ex_rwaddr = 0; id_rs1addr = 0; cyc();
        load_x5(); id_rs1addr = 7; id_rs2addr = 5; id_use_rs2 = 0; cyc();
        idle(); cyc();
        // MDU: 5 stalled cycles then done.
        ex_mdu_start = 1; cyc();
        idle(); repeat (5) cyc();
        mdu_done = 1; cyc();
        idle(); cyc();
        // Start with done in the same cycle.
        ex_mdu_start = 1; mdu_done = 1; cyc();
        idle(); cyc();
        // Redirect wins over a load-use hazard.
        load_x5(); ex_redirect = 1; cyc();
        idle(); cyc();
        // Memory wait in the middle of a multiply/divide.
        ex_mdu_start = 1; cyc();
        idle(); repeat (2) cyc();
        mem_busy = 1; repeat (3) cyc();
        mem_busy = 0; repeat (2) cyc();
        mdu_done = 1; cyc();
        idle(); cyc();
        // Memory wait entered from LDUSE resumes in RUN.
        load_x5(); cyc();
        idle(); mem_busy = 1; cyc();
        mem_busy = 0; load_x5(); cyc();
        idle(); cyc();
        // Reset mid-MDU.
        ex_mdu_start = 1; cyc();
        idle(); repeat (3) cyc();
        rst_n = 0; cyc();
        idle(); repeat (2) cyc();
        // Watchdog timeout, then sticky flag survives further traffic.
        ex_mdu_start = 1; cyc();
        idle(); repeat (260) cyc();
        load_x5(); cyc();
        idle(); cyc();
        // Randomized traffic.
        repeat (4000) begin rand_inputs(); cyc(); end
        idle(); cyc();
        @(negedge clk);
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain got=%0d exp=0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
